// File: rtl/p_mul_pipe_if.sv
// p_mul_pipe_if: beat/result handshake bundle for p_mul_pipe
//   in_valid/in_ready, in_1..in_4 (W), in_mode (2), in_last : operand beat
//   out_valid/out_ready, out (ACC_W), out_ovf              : result beat
interface p_mul_pipe_if #(
  parameter int W = 48,
  parameter int ACC_W = 2 * W + 10
);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_1;
  logic [W-1:0] in_2;
  logic [W-1:0] in_3;
  logic [W-1:0] in_4;
  logic [1:0] in_mode;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out;
  logic out_ovf;
  modport master (
    output in_valid, in_1, in_2, in_3, in_4, in_mode, in_last, out_ready,
    input in_ready, out_valid, out, out_ovf
  );
  modport slave (
    input in_valid, in_1, in_2, in_3, in_4, in_mode, in_last, out_ready,
    output in_ready, out_valid, out, out_ovf
  );
endinterface

// File: rtl/p_mul_pipe.sv
// p_mul_pipe: pipelined (in_1 op in_2)*(in_3 op in_4) with sum, signed-diff and burst-accumulate modes
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of p_mul_pipe_if (operand beat in, result beat out)
module p_mul_pipe #(
  parameter int W = 48,
  parameter int MUL_STAGES = 3,
  parameter int ACC_W = 2 * W + 10
) (
  input logic clk,
  input logic rst,
  p_mul_pipe_if.slave bus
);
  localparam int L = MUL_STAGES - 1;
  logic w_stall;
  logic r_s_valid, r_s_sgn, r_s_acc, r_s_last;
  logic [W:0] r_s_a, r_s_b;
  logic [MUL_STAGES-1:0] r_m_valid, r_m_acc, r_m_last;
  logic [ACC_W-1:0] r_m_p [MUL_STAGES];
  logic r_f_valid, r_burst, r_ovf, r_acc_ovf;
  logic [ACC_W-1:0] r_out, r_acc;
  logic [ACC_W-1:0] w_ea, w_eb, w_prod, w_acc_nxt;
  logic [ACC_W:0] w_sum;
  logic w_ovf_nxt;
  assign w_stall = r_f_valid && !bus.out_ready;
  assign bus.in_ready = !w_stall;
  assign bus.out_valid = r_f_valid;
  assign bus.out = r_out;
  assign bus.out_ovf = r_ovf;
  // Operands widened to ACC_W so one modular multiply serves both the unsigned and signed modes.
  always_comb begin
    w_ea = {{(ACC_W-W-1){r_s_sgn & r_s_a[W]}}, r_s_a};
    w_eb = {{(ACC_W-W-1){r_s_sgn & r_s_b[W]}}, r_s_b};
    w_prod = w_ea * w_eb;
    w_sum = {1'b0, r_acc} + {1'b0, r_m_p[L]};
    w_acc_nxt = r_burst ? w_sum[ACC_W-1:0] : r_m_p[L];
    w_ovf_nxt = r_burst && (r_acc_ovf || w_sum[ACC_W]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_s_valid, r_s_sgn, r_s_acc, r_s_last, r_s_a, r_s_b} <= '0;
      {r_m_valid, r_m_acc, r_m_last} <= '0;
      for (int i = 0; i < MUL_STAGES; i++) r_m_p[i] <= '0;
      {r_f_valid, r_burst, r_ovf, r_acc_ovf, r_out, r_acc} <= '0;
    end else if (!w_stall) begin
      r_s_valid <= bus.in_valid;
      r_s_sgn <= bus.in_mode == 2'd1;
      r_s_acc <= bus.in_mode == 2'd2;
      r_s_last <= bus.in_last;
      r_s_a <= bus.in_mode == 2'd1 ? {1'b0, bus.in_1} - {1'b0, bus.in_2} : {1'b0, bus.in_1} + {1'b0, bus.in_2};
      r_s_b <= bus.in_mode == 2'd1 ? {1'b0, bus.in_3} - {1'b0, bus.in_4} : {1'b0, bus.in_3} + {1'b0, bus.in_4};
      r_m_valid[0] <= r_s_valid;
      r_m_acc[0] <= r_s_acc;
      r_m_last[0] <= r_s_last;
      r_m_p[0] <= w_prod;
      for (int i = 1; i < MUL_STAGES; i++) begin
        r_m_valid[i] <= r_m_valid[i-1];
        r_m_acc[i] <= r_m_acc[i-1];
        r_m_last[i] <= r_m_last[i-1];
        r_m_p[i] <= r_m_p[i-1];
      end
      r_f_valid <= r_m_valid[L] && (!r_m_acc[L] || r_m_last[L]);
      if (r_m_valid[L] && r_m_acc[L]) begin
        r_acc <= w_acc_nxt;
        r_acc_ovf <= w_ovf_nxt;
        r_burst <= !r_m_last[L];
        if (r_m_last[L]) begin
          r_out <= w_acc_nxt;
          r_ovf <= w_ovf_nxt;
        end
      end else if (r_m_valid[L]) begin
        // A non-accumulate beat abandons any open burst.
        r_out <= r_m_p[L];
        r_ovf <= 1'b0;
        r_burst <= 1'b0;
      end
    end
  end
endmodule
